// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end types and constants.
// Holds the address/instruction widths, the PC step and the fetch entry layout.
package legv8_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush.
// Ports: clk_i, rst_ni, push_i, pop_i, flush_i, din_i -> count_o, head_o.
module fetch_fifo
    import legv8_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_entry_t  din_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t  head_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Flush wins over everything; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PW'(1);
            if (pop_i)  rd_d = rd_q + PW'(1);
            if (push_i && !pop_i)
                cnt_d = cnt_q + CW'(1);
            else if (pop_i && !push_i)
                cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i)
            mem_q[wr_q] <= din_i;
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, reads imem, queues {pc,instr} pairs.
// Ports: CLOCK/RESET_N, IMEM_ADDR/DATA, BRANCH_*, INSTR_* handshake, OCCUPANCY.
module instr_fetch_queue
    import legv8_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    output logic [ADDR_W-1:0]  IMEM_ADDR,
    input  logic [INSTR_W-1:0] IMEM_DATA,
    input  logic               BRANCH_TAKEN,
    input  logic [ADDR_W-1:0]  BRANCH_TARGET,
    output logic               INSTR_VALID,
    output logic [INSTR_W-1:0] INSTRUCTION,
    output logic [ADDR_W-1:0]  INSTR_PC,
    input  logic               INSTR_READY,
    output logic [CW-1:0]      OCCUPANCY
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     count;
    fetch_entry_t      head;
    fetch_entry_t      din;
    logic              valid;
    logic              pop;
    logic              push;

    assign valid = (count != '0);
    assign pop   = valid && INSTR_READY;

    // A full queue still accepts a word when the head leaves this cycle.
    // Redirect suppresses the push but not the pop: the core has
    // already taken that head.
    assign push  = !BRANCH_TAKEN && ((count < FULL) || pop);

    assign din.pc    = pc_q;
    assign din.instr = IMEM_DATA;

    always_comb begin
        pc_d = pc_q;
        if (BRANCH_TAKEN)
            pc_d = BRANCH_TARGET & ~64'd3;
        else if (push)
            pc_d = pc_q + PC_INC;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLOCK),
        .rst_ni  (RESET_N),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (BRANCH_TAKEN),
        .din_i   (din),
        .count_o (count),
        .head_o  (head)
    );

    assign IMEM_ADDR   = pc_q;
    assign INSTR_VALID = valid;
    assign INSTRUCTION = valid ? head.instr : '0;
    assign INSTR_PC    = valid ? head.pc : '0;
    assign OCCUPANCY   = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue.
// imem returns the low 32 bits of the address as the instruction word.
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        br_taken;
    logic [63:0] br_target;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] ipc;
    logic        ready;
    logic [2:0]  occ;

    int errs;
    int checks;
    logic [63:0] sb [$];

    assign imem_data = imem_addr[31:0];

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .CLOCK         (clk),
        .RESET_N       (rst_n),
        .IMEM_ADDR     (imem_addr),
        .IMEM_DATA     (imem_data),
        .BRANCH_TAKEN  (br_taken),
        .BRANCH_TARGET (br_target),
        .INSTR_VALID   (valid),
        .INSTRUCTION   (instr),
        .INSTR_PC      (ipc),
        .INSTR_READY   (ready),
        .OCCUPANCY     (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Compare the head against the scoreboard when a handshake is about
    // to complete, then advance one clock (sampling point: edge + 1).
    task automatic tick();
        logic [63:0] e;
        if (valid && ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", ipc, 64'hdead);
            end else begin
                e = sb.pop_front();
                chk("head_pc", ipc, e);
                chk("head_instr", {32'h0, instr}, {32'h0, e[31:0]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ready    = 1'b0;
        br_taken = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        errs      = 0;
        checks    = 0;
        rst_n     = 1'b0;
        ready     = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        #12;

        // Reset state
        chk("rst_valid", {63'h0, valid}, 64'h0);
        chk("rst_instr", {32'h0, instr}, 64'h0);
        chk("rst_pc", ipc, 64'h0);
        chk("rst_occ", {61'h0, occ}, 64'h0);
        chk("rst_addr", imem_addr, 64'h0);

        // Streaming with ready high: one per cycle, occupancy 1
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 10; i++) sb.push_back(64'(i * 4));
        tick();
        chk("first_valid", {63'h0, valid}, 64'h1);
        for (int i = 0; i < 10; i++) begin
            chk("stream_occ", {61'h0, occ}, 64'h1);
            tick();
        end
        chk("stream_drained", 64'(sb.size()), 64'h0);

        // Backpressure, then drain from full with ready high
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        chk("bp_occ", {61'h0, occ}, 64'h4);
        chk("bp_addr", imem_addr, 64'h10);
        for (int i = 0; i < 8; i++) sb.push_back(64'(i * 4));
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", {63'h0, valid}, 64'h1);
            chk("full_occ", {61'h0, occ}, 64'h4);
            tick();
        end
        chk("drain_done", 64'(sb.size()), 64'h0);

        // Redirect with a full queue
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("pre_br_occ", {61'h0, occ}, 64'h4);
        br_taken  = 1'b1;
        br_target = 64'h103;
        tick();
        br_taken = 1'b0;
        chk("br_valid", {63'h0, valid}, 64'h0);
        chk("br_addr", imem_addr, 64'h100);
        chk("br_occ", {61'h0, occ}, 64'h0);
        tick();
        chk("br_head_valid", {63'h0, valid}, 64'h1);
        chk("br_head_pc", ipc, 64'h100);
        sb.push_back(64'h100);
        sb.push_back(64'h104);
        ready = 1'b1;
        tick();
        tick();
        chk("br_sb_done", 64'(sb.size()), 64'h0);

        // Redirect coincident with a handshake on PC 0
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        sb.push_back(64'h0);
        sb.push_back(64'h200);
        sb.push_back(64'h204);
        ready     = 1'b1;
        br_taken  = 1'b1;
        br_target = 64'h200;
        tick();
        br_taken = 1'b0;
        chk("hs_br_valid", {63'h0, valid}, 64'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("hs_br_done", 64'(sb.size()), 64'h0);

        // Asynchronous reset mid-stream with 3 entries
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        chk("ar_occ_before", {61'h0, occ}, 64'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {63'h0, valid}, 64'h0);
        chk("ar_pc", ipc, 64'h0);
        chk("ar_instr", {32'h0, instr}, 64'h0);
        chk("ar_occ", {61'h0, occ}, 64'h0);
        chk("ar_addr", imem_addr, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_restart_valid", {63'h0, valid}, 64'h1);
        chk("ar_restart_pc", ipc, 64'h0);

        // PC wrap from the top of the address space
        do_reset();
        br_taken  = 1'b1;
        br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        br_taken = 1'b0;
        tick();
        chk("wrap_head", ipc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr", imem_addr, 64'h0);
        tick();
        chk("wrap_occ", {61'h0, occ}, 64'h2);
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        sb.push_back(64'h0);
        ready = 1'b1;
        tick();
        tick();
        chk("wrap_sb_done", 64'(sb.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage with a small prefetch buffer, sitting between instruction memory `imem` and the decode input of the LEGv8 core. It owns the fetch PC, reads `imem` combinationally, and pushes `{pc, instruction}` pairs into a FIFO. The core consumes the pairs over a valid/ready handshake. A taken branch from execute flushes the queue and redirects fetch.

## Interface
- `DEPTH`, 4: queue entries; a power of two, ≥2.
- `RESET_PC`, 64'h0: fetch PC loaded at reset; bits [1:0] must be 0.
- `CLOCK` in 1: single clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `IMEM_ADDR` out 64: current fetch PC, driven to `imem`.
- `IMEM_DATA` in 32: instruction word returned combinationally by `imem` for `IMEM_ADDR`.
- `BRANCH_TAKEN` in 1: redirect request, sampled at the rising edge.
- `BRANCH_TARGET` in 64: redirect address; bits [1:0] are ignored and forced to 0.
- `INSTR_VALID` out 1: head entry is valid.
- `INSTRUCTION` out 32: head instruction; 0 when the queue is empty.
- `INSTR_PC` out 64: PC of the head instruction; 0 when the queue is empty.
- `INSTR_READY` in 1: consumer accepts the head this cycle.
- `OCCUPANCY` out $clog2(DEPTH+1): number of valid entries.

## Operation
- Reset state:
  - fetch PC = `RESET_PC`
  - read and write pointers = 0, count = 0
  - `INSTR_VALID`=0, `INSTRUCTION`=0, `INSTR_PC`=0, `OCCUPANCY`=0
  - `IMEM_ADDR`=`RESET_PC`
- Pop: occurs when `INSTR_VALID && INSTR_READY`. The read pointer advances.
- Push: occurs when `count < DEPTH`, or when `count == DEPTH` and a pop happens in the same cycle. On a push:
  - `{IMEM_ADDR, IMEM_DATA}` is written at the write pointer.
  - The write pointer advances.
  - Fetch PC is incremented by 4.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Redirect (`BRANCH_TAKEN`=1) has priority over push and pop:
  - All entries are invalidated: count=0 and pointers=0.
  - Fetch PC = `{BRANCH_TARGET[63:2], 2'b00}`.
  - No push occurs in that cycle.
  - A handshake completing in the same cycle still counts as consumed by the core. The queue does not replay it.
- Fetch PC arithmetic is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- Pointers wrap modulo `DEPTH`.
- Full and empty are distinguished by count, not by pointer equality.
- Outputs derived from state:
  - `INSTR_VALID` = (count != 0).
  - `INSTRUCTION` and `INSTR_PC` are muxed from the head entry, and gated to 0 when empty.
  - `OCCUPANCY` = count.
- There is no halt detection. Fetch runs while space exists.

## Timing
- `IMEM_ADDR` is registered (fetch PC). `imem` is combinational, so the word is captured at the same edge it is addressed.
- Latency from reset release:
  - The first rising edge with `RESET_N`=1 pushes the `RESET_PC` word.
  - `INSTR_VALID`=1 immediately after that edge.
- With `INSTR_READY` held at 1, throughput is 1 instruction/cycle and occupancy stays at 1.
- Redirect-to-valid: 2 edges.
  - Edge N flushes and loads the target.
  - Edge N+1 pushes the target word.
  - `INSTR_VALID`=1 after N+1.
- `INSTR_READY` may be held low indefinitely:
  - Fetch stops at count=`DEPTH`.
  - `IMEM_ADDR` holds at the PC of the first un-fetched instruction.
- Asynchronous reset mid-operation:
  - All state clears immediately.
  - `INSTR_VALID` drops without waiting for a clock edge.
  - Queued entries are discarded.
- `BRANCH_TAKEN` and `BRANCH_TARGET` must be stable around the rising edge. No combinational path exists from them to any output.

## Structure
- Shared package `legv8_pkg` holds:
  - `ADDR_W`=64, `INSTR_W`=32, `PC_INC`=4
  - typedef `fetch_entry_t` = `{pc[63:0], instr[31:0]}`
- Sub-module `fetch_fifo`:
  - Generic `DEPTH`×entry synchronous FIFO.
  - Inputs: push, pop, flush.
  - Outputs: count and head.
- `instr_fetch_queue` wraps `fetch_fifo` with the fetch-PC register, the redirect priority logic and the output gating.

## Test plan
- Reset then release, `INSTR_READY`=1, `imem` returning word=`addr`:
  - Consumer sees PCs 0, 4, 8, 12… on consecutive cycles, each `INSTRUCTION`==`INSTR_PC`[31:0].
  - `OCCUPANCY` stays at 1.
- Backpressure: `INSTR_READY`=0 for 10 cycles after reset:
  - `OCCUPANCY` reaches 4 and then holds.
  - `IMEM_ADDR` holds at 16.
  - Raising ready drains PCs 0, 4, 8, 12, then 16 with no gap.
- Redirect with the queue full (PCs 0–12 queued), `BRANCH_TAKEN`=1, target=0x103:
  - Next cycle `INSTR_VALID`=0 and `IMEM_ADDR`=0x100.
  - The cycle after, `INSTR_PC`=0x100.
- Redirect coincident with a handshake on head PC 0:
  - PC 0 is consumed once.
  - The queue flushes and the next valid PC is the target.
- Full queue with ready=1 in the same cycle:
  - Push and pop both occur, occupancy stays at 4, and no entry is dropped or duplicated (PC sequence checked).
- Assert `RESET_N`=0 asynchronously mid-stream with 3 entries queued:
  - Outputs go to 0 at once.
  - After release, fetch restarts at `RESET_PC`.
- Redirect target 64'hFFFF_FFFF_FFFF_FFFC: the next fetched PC is 0 (wrap).
